// File: rtl/difftest_sim_ctrl_if.sv
// Bus bundle between the difftest simulation controller and the harness driving it.
// The controller takes the slave side; the harness or testbench takes the master side.
interface difftest_sim_ctrl_if #(
    parameter int unsigned NUM_CORES = 2,
    parameter int unsigned CYCLE_W   = 64
);
    logic [CYCLE_W-1:0]     cfg_max_cycles;
    logic [CYCLE_W-1:0]     cfg_max_instrs;
    logic                   core_reset;
    logic                   init_req;
    logic                   init_ack;
    logic [NUM_CORES-1:0]   commit;
    logic [NUM_CORES-1:0]   trap_valid;
    logic [8*NUM_CORES-1:0] trap_code;
    logic                   perf_dump;
    logic                   finish;
    logic [7:0]             finish_code;
    logic [7:0]             finish_core;
    logic [CYCLE_W-1:0]     cycles;
    logic [CYCLE_W-1:0]     instrs;
    logic                   uart_in_valid;
    logic [7:0]             uart_in_ch;
    logic                   uart_out_valid;
    logic [7:0]             uart_out_ch;
    logic                   uart_out_ready;
    logic                   uart_overflow;

    modport master (
        output cfg_max_cycles, cfg_max_instrs, init_ack, commit, trap_valid, trap_code,
               uart_in_valid, uart_in_ch, uart_out_ready,
        input  core_reset, init_req, perf_dump, finish, finish_code, finish_core,
               cycles, instrs, uart_out_valid, uart_out_ch, uart_overflow
    );

    modport slave (
        input  cfg_max_cycles, cfg_max_instrs, init_ack, commit, trap_valid, trap_code,
               uart_in_valid, uart_in_ch, uart_out_ready,
        output core_reset, init_req, perf_dump, finish, finish_code, finish_core,
               cycles, instrs, uart_out_valid, uart_out_ch, uart_overflow
    );
endinterface

// File: rtl/difftest_sim_ctrl.sv
// Difftest simulation controller: sequences core reset/init, counts cycles and retired
// instructions, stops on trap or limit, pulses perf_dump, and buffers UART output.
module difftest_sim_ctrl #(
    parameter int unsigned NUM_CORES   = 2,
    parameter int unsigned CYCLE_W     = 64,
    parameter int unsigned HOLD_CYCLES = 50,
    parameter int unsigned DUMP_CYCLES = 50,
    parameter int unsigned UART_DEPTH  = 16
) (
    input logic                clock,
    input logic                reset,
    difftest_sim_ctrl_if.slave bus
);
    localparam int unsigned AW      = $clog2(UART_DEPTH);
    localparam int unsigned CNT_MAX = (HOLD_CYCLES > DUMP_CYCLES) ? HOLD_CYCLES : DUMP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [2:0] S_HOLD = 3'd0;
    localparam logic [2:0] S_INIT = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_DUMP = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CYCLE_W-1:0] cycles_q, cycles_d, instrs_q, instrs_d;
    logic [7:0]         code_q, code_d, core_q, core_d;
    logic               core_reset_q, init_req_q, perf_dump_q, finish_q;

    logic [CYCLE_W:0]   inc, cyc_sum, ins_sum;
    logic [CYCLE_W-1:0] cyc_next, ins_next;
    logic               trap_hit;
    logic [7:0]         trap_cd, trap_core;

    logic [7:0]         mem [UART_DEPTH];
    logic [AW:0]        wr_q, wr_d, rd_q, rd_d;
    logic               ovf_q, ovf_d;
    logic               empty, full, push_req, push, pop;

    // Next-state, counter and stop-cause logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        cycles_d  = cycles_q;
        instrs_d  = instrs_q;
        code_d    = code_q;
        core_d    = core_q;
        inc       = '0;
        trap_hit  = 1'b0;
        trap_cd   = '0;
        trap_core = '0;

        for (int i = 0; i < int'(NUM_CORES); i++) begin
            inc = inc + (CYCLE_W+1)'(bus.commit[i]);
        end
        cyc_sum  = {1'b0, cycles_q} + (CYCLE_W+1)'(1);
        ins_sum  = {1'b0, instrs_q} + inc;
        cyc_next = cyc_sum[CYCLE_W] ? '1 : cyc_sum[CYCLE_W-1:0];
        ins_next = ins_sum[CYCLE_W] ? '1 : ins_sum[CYCLE_W-1:0];

        // Descending scan so the lowest-index trapping core wins
        for (int i = int'(NUM_CORES) - 1; i >= 0; i--) begin
            if (bus.trap_valid[i]) begin
                trap_hit  = 1'b1;
                trap_cd   = bus.trap_code[8*i +: 8];
                trap_core = 8'(i);
            end
        end

        case (state_q)
            S_HOLD: if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) state_d = S_INIT;
            S_INIT: if (bus.init_ack) state_d = S_RUN;
            S_RUN: begin
                cycles_d = cyc_next;
                instrs_d = ins_next;
                if (trap_hit) begin
                    state_d = S_DUMP;
                    code_d  = trap_cd;
                    core_d  = trap_core;
                end else if ((bus.cfg_max_instrs != '0) && (ins_next >= bus.cfg_max_instrs)) begin
                    state_d = S_DUMP;
                    code_d  = 8'h09;
                    core_d  = 8'hFF;
                end else if ((bus.cfg_max_cycles != '0) && (cyc_next >= bus.cfg_max_cycles)) begin
                    state_d = S_DUMP;
                    code_d  = 8'hFE;
                    core_d  = 8'hFF;
                end
            end
            S_DUMP: if (cnt_q == CNT_W'(DUMP_CYCLES - 1)) state_d = S_DONE;
            S_DONE: state_d = S_DONE;
            default: state_d = S_HOLD;
        endcase

        if ((state_d == state_q) && ((state_q == S_HOLD) || (state_q == S_DUMP))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // UART FIFO control; a pop frees the slot a same-cycle push needs when full
    always_comb begin
        empty    = (wr_q == rd_q);
        full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        push_req = bus.uart_in_valid && ((state_q == S_RUN) || (state_q == S_DUMP));
        pop      = !empty && bus.uart_out_ready;
        push     = push_req && (!full || pop);
        wr_d     = wr_q + (AW+1)'(push);
        rd_d     = rd_q + (AW+1)'(pop);
        ovf_d    = ovf_q | (push_req && !push);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_HOLD;
            cnt_q        <= '0;
            cycles_q     <= '0;
            instrs_q     <= '0;
            code_q       <= '0;
            core_q       <= '0;
            core_reset_q <= 1'b1;
            init_req_q   <= 1'b0;
            perf_dump_q  <= 1'b0;
            finish_q     <= 1'b0;
            wr_q         <= '0;
            rd_q         <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cycles_q     <= cycles_d;
            instrs_q     <= instrs_d;
            code_q       <= code_d;
            core_q       <= core_d;
            core_reset_q <= (state_d == S_HOLD);
            init_req_q   <= (state_q != S_INIT) && (state_d == S_INIT);
            perf_dump_q  <= (state_d == S_DUMP);
            finish_q     <= (state_d == S_DONE);
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            ovf_q        <= ovf_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_q[AW-1:0]] <= bus.uart_in_ch;
    end

    assign bus.core_reset     = core_reset_q;
    assign bus.init_req       = init_req_q;
    assign bus.perf_dump      = perf_dump_q;
    assign bus.finish         = finish_q;
    assign bus.finish_code    = code_q;
    assign bus.finish_core    = core_q;
    assign bus.cycles         = cycles_q;
    assign bus.instrs         = instrs_q;
    assign bus.uart_out_valid = !empty;
    assign bus.uart_out_ch    = mem[rd_q[AW-1:0]];
    assign bus.uart_overflow  = ovf_q;
endmodule

// File: tb/tb_difftest_sim_ctrl.sv
// Testbench for difftest_sim_ctrl: directed and randomized runs checked against a
// behavioural model of counting, stop causes, dump length and the UART queue.
module tb_difftest_sim_ctrl;
    localparam int NC = 2;
    localparam int CW = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    difftest_sim_ctrl_if #(.NUM_CORES(NC), .CYCLE_W(CW)) bus ();

    difftest_sim_ctrl #(
        .NUM_CORES(NC), .CYCLE_W(CW), .HOLD_CYCLES(50), .DUMP_CYCLES(50), .UART_DEPTH(16)
    ) dut (
        .clock(clk),
        .reset(rst),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [63:0] m_cycles, m_instrs;
    logic [7:0]  m_code, m_core;
    bit          m_stop;
    logic [7:0]  uq[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cfg_max_cycles = '0;
        bus.cfg_max_instrs = '0;
        bus.init_ack       = 1'b0;
        bus.commit         = '0;
        bus.trap_valid     = '0;
        bus.trap_code      = '0;
        bus.uart_in_valid  = 1'b0;
        bus.uart_in_ch     = '0;
        bus.uart_out_ready = 1'b0;
    endtask

    // Reset, hold, init handshake; leaves the DUT one cycle into RUN with zeroed counters
    task automatic bring_up(input bit noisy);
        int hold;
        int pulses;
        bit seen;
        idle_inputs();
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_core_reset", 64'(bus.core_reset), 64'(1));
        chk("rst_perf_dump", 64'(bus.perf_dump), 64'(0));
        chk("rst_finish", 64'(bus.finish), 64'(0));
        chk("rst_init_req", 64'(bus.init_req), 64'(0));
        chk("rst_cycles", bus.cycles, 64'(0));
        chk("rst_instrs", bus.instrs, 64'(0));
        chk("rst_uart_valid", 64'(bus.uart_out_valid), 64'(0));
        chk("rst_finish_code", 64'(bus.finish_code), 64'(0));
        if (noisy) begin
            bus.commit        = 2'b11;
            bus.trap_valid    = 2'b01;
            bus.trap_code     = 16'h0505;
            bus.uart_in_valid = 1'b1;
            bus.uart_in_ch    = 8'h41;
        end
        rst    = 1'b0;
        hold   = bus.core_reset ? 1 : 0;
        pulses = 0;
        seen   = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            tick();
            if (bus.core_reset) hold++;
            if (bus.init_req) begin
                pulses++;
                seen = 1'b1;
            end
        end
        chk("hold_len", 64'(hold), 64'(50));
        chk("init_seen", 64'(seen), 64'(1));
        tick();
        if (bus.init_req) pulses++;
        idle_inputs();
        bus.init_ack = 1'b1;
        tick();
        if (bus.init_req) pulses++;
        bus.init_ack = 1'b0;
        chk("init_pulses", 64'(pulses), 64'(1));
        chk("run_core_reset", 64'(bus.core_reset), 64'(0));
        chk("run_uart_empty", 64'(bus.uart_out_valid), 64'(0));
        chk("run_cycles0", bus.cycles, 64'(0));
        chk("run_instrs0", bus.instrs, 64'(0));
        m_cycles = '0;
        m_instrs = '0;
        m_code   = '0;
        m_core   = '0;
        m_stop   = 1'b0;
        uq.delete();
    endtask

    // One RUN cycle: model predicts counters and the stop decision, then DUT is compared
    task automatic run_step(input logic [1:0] cm, input logic [1:0] tv, input logic [15:0] tc);
        logic [64:0] s;
        bit hit;
        m_cycles = (m_cycles == '1) ? m_cycles : m_cycles + 64'd1;
        s        = {1'b0, m_instrs} + 65'($countones(cm));
        m_instrs = s[64] ? '1 : s[63:0];
        hit      = 1'b0;
        for (int i = 0; i < NC; i++) begin
            if (!hit && tv[i]) begin
                hit    = 1'b1;
                m_code = tc[8*i +: 8];
                m_core = 8'(i);
            end
        end
        if (!hit && bus.cfg_max_instrs != '0 && m_instrs >= bus.cfg_max_instrs) begin
            hit    = 1'b1;
            m_code = 8'h09;
            m_core = 8'hFF;
        end
        if (!hit && bus.cfg_max_cycles != '0 && m_cycles >= bus.cfg_max_cycles) begin
            hit    = 1'b1;
            m_code = 8'hFE;
            m_core = 8'hFF;
        end
        m_stop = hit;
        bus.commit     = cm;
        bus.trap_valid = tv;
        bus.trap_code  = tc;
        tick();
        bus.commit     = '0;
        bus.trap_valid = '0;
        bus.trap_code  = '0;
        chk("run_cycles", bus.cycles, m_cycles);
        chk("run_instrs", bus.instrs, m_instrs);
        chk("run_perf_dump", 64'(bus.perf_dump), 64'(m_stop));
        if (m_stop) begin
            chk("stop_code", 64'(bus.finish_code), 64'(m_code));
            chk("stop_core", 64'(bus.finish_core), 64'(m_core));
        end
    endtask

    // Measures the dump pulse, then checks DONE holds everything frozen under noisy inputs
    task automatic finish_phase();
        int n;
        n = 0;
        while (bus.perf_dump && n < 200) begin
            n++;
            tick();
        end
        chk("dump_len", 64'(n), 64'(50));
        chk("done_finish", 64'(bus.finish), 64'(1));
        bus.commit     = 2'b11;
        bus.trap_valid = 2'b01;
        bus.trap_code  = 16'h7777;
        repeat (3) tick();
        idle_inputs();
        chk("done_finish_hold", 64'(bus.finish), 64'(1));
        chk("done_perf_dump", 64'(bus.perf_dump), 64'(0));
        chk("done_cycles", bus.cycles, m_cycles);
        chk("done_instrs", bus.instrs, m_instrs);
        chk("done_code", 64'(bus.finish_code), 64'(m_code));
        chk("done_core", 64'(bus.finish_core), 64'(m_core));
    endtask

    task automatic rand_run(input logic [63:0] mc, input logic [63:0] mi, input int trap_rate);
        logic [1:0]  cm, tv;
        logic [15:0] tc;
        bus.cfg_max_cycles = mc;
        bus.cfg_max_instrs = mi;
        for (int k = 0; k < 400 && !m_stop; k++) begin
            cm = 2'($urandom_range(0, 3));
            tv = '0;
            if (trap_rate > 0 && $urandom_range(0, trap_rate - 1) == 0) tv = 2'($urandom_range(1, 3));
            tc = {8'($urandom_range(1, 255)), 8'($urandom_range(1, 255))};
            run_step(cm, tv, tc);
        end
        chk("rand_stopped", 64'(m_stop), 64'(1));
    endtask

    initial begin
        logic [7:0] ch, exp_ch;
        int got;
        rst = 1'b1;
        idle_inputs();

        // Bring-up with commits, traps and UART noise during HOLD/INIT
        bring_up(1'b1);

        // Trap on core 1 after ten double-commit cycles
        repeat (10) run_step(2'b11, 2'b00, 16'h0000);
        run_step(2'b00, 2'b10, 16'h0100);
        chk("a_instrs", bus.instrs, 64'd20);
        chk("a_code", 64'(bus.finish_code), 64'h01);
        chk("a_core", 64'(bus.finish_core), 64'd1);
        finish_phase();

        // Both cores trap as the instruction limit is reached
        bring_up(1'b0);
        bus.cfg_max_instrs = 64'd6;
        run_step(2'b11, 2'b00, 16'h0000);
        run_step(2'b11, 2'b00, 16'h0000);
        run_step(2'b11, 2'b11, 16'h4433);
        chk("b_code", 64'(bus.finish_code), 64'h33);
        chk("b_core", 64'(bus.finish_core), 64'd0);
        finish_phase();

        // Cycle limit only
        bring_up(1'b0);
        rand_run(64'd100, 64'd0, 0);
        chk("c_cycles", bus.cycles, 64'd100);
        chk("c_code", 64'(bus.finish_code), 64'hFE);
        finish_phase();

        // Instruction and cycle limits hit together: instruction limit wins
        bring_up(1'b0);
        bus.cfg_max_cycles = 64'd5;
        bus.cfg_max_instrs = 64'd10;
        repeat (5) run_step(2'b11, 2'b00, 16'h0000);
        chk("d_code", 64'(bus.finish_code), 64'h09);
        chk("d_core", 64'(bus.finish_core), 64'hFF);
        finish_phase();

        // Randomized runs with sparse traps
        for (int r = 0; r < 2; r++) begin
            bring_up(1'b0);
            rand_run(64'($urandom_range(150, 250)), 64'($urandom_range(60, 200)), 40);
            finish_phase();
        end

        // UART: fill, full push+pop, overflow, drain in order
        bring_up(1'b0);
        for (int k = 0; k < 16; k++) begin
            ch = 8'($urandom_range(0, 255));
            bus.uart_in_valid = 1'b1;
            bus.uart_in_ch    = ch;
            uq.push_back(ch);
            tick();
        end
        bus.uart_in_valid = 1'b0;
        chk("u_full_no_ovf", 64'(bus.uart_overflow), 64'(0));
        chk("u_valid", 64'(bus.uart_out_valid), 64'(1));
        ch = 8'hA5;
        exp_ch = uq.pop_front();
        chk("u_head", 64'(bus.uart_out_ch), 64'(exp_ch));
        bus.uart_in_valid  = 1'b1;
        bus.uart_in_ch     = ch;
        bus.uart_out_ready = 1'b1;
        uq.push_back(ch);
        tick();
        bus.uart_out_ready = 1'b0;
        chk("u_pushpop_no_ovf", 64'(bus.uart_overflow), 64'(0));
        for (int k = 0; k < 4; k++) begin
            bus.uart_in_ch = 8'($urandom_range(0, 255));
            tick();
        end
        bus.uart_in_valid = 1'b0;
        chk("u_overflow", 64'(bus.uart_overflow), 64'(1));
        bus.uart_out_ready = 1'b1;
        got = 0;
        for (int k = 0; k < 40 && uq.size() > 0; k++) begin
            if (bus.uart_out_valid) begin
                exp_ch = uq.pop_front();
                chk("u_drain_ch", 64'(bus.uart_out_ch), 64'(exp_ch));
                got++;
            end
            tick();
        end
        chk("u_drain_count", 64'(got), 64'(16));
        chk("u_empty", 64'(bus.uart_out_valid), 64'(0));
        chk("u_ovf_sticky", 64'(bus.uart_overflow), 64'(1));
        idle_inputs();

        // Reset in the middle of DUMP with characters buffered
        bring_up(1'b0);
        bus.cfg_max_cycles = 64'd3;
        repeat (3) run_step(2'b01, 2'b00, 16'h0000);
        bus.uart_in_valid = 1'b1;
        bus.uart_in_ch    = 8'h5A;
        repeat (5) tick();
        bus.uart_in_valid = 1'b0;
        chk("g_in_dump", 64'(bus.perf_dump), 64'(1));
        chk("g_uart_buffered", 64'(bus.uart_out_valid), 64'(1));
        rst = 1'b1;
        tick();
        chk("g_perf_dump", 64'(bus.perf_dump), 64'(0));
        chk("g_core_reset", 64'(bus.core_reset), 64'(1));
        chk("g_cycles", bus.cycles, 64'(0));
        chk("g_instrs", bus.instrs, 64'(0));
        chk("g_uart_empty", 64'(bus.uart_out_valid), 64'(0));
        chk("g_finish_code", 64'(bus.finish_code), 64'(0));
        chk("g_finish", 64'(bus.finish), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/difftest_sim_ctrl.md
DIFFTEST_SIM_CTRL -- requirements
Module: difftest_sim_ctrl

Interface
REQ-001 SHALL have parameter NUM_CORES, default 2, number of cores stepped and monitored.
REQ-002 SHALL have parameter CYCLE_W, default 64, width of the cycle and instruction counters.
REQ-003 SHALL have parameter HOLD_CYCLES, default 50, cycles core_reset stays high after reset falls.
REQ-004 SHALL have parameter DUMP_CYCLES, default 50, length of the perf_dump pulse.
REQ-005 SHALL have parameter UART_DEPTH, default 16 (power of two), UART buffer entries.
REQ-006 SHALL have ports: clock input 1, sole clock; reset input 1, synchronous active-high.
REQ-007 SHALL have ports: cfg_max_cycles input CYCLE_W, 0 = unlimited; cfg_max_instrs input CYCLE_W, 0 = unlimited.
REQ-008 SHALL have ports: core_reset output 1; init_req output 1, one-cycle pulse; init_ack input 1.
REQ-009 SHALL have ports: commit input NUM_CORES, one bit per retired instruction per core.
REQ-010 SHALL have ports: trap_valid input NUM_CORES; trap_code input 8*NUM_CORES, core i in bits [8i+7:8i], code must be nonzero.
REQ-011 SHALL have ports: perf_dump output 1; finish output 1; finish_code output 8; finish_core output 8.
REQ-012 SHALL have ports: cycles output CYCLE_W; instrs output CYCLE_W.
REQ-013 SHALL have ports: uart_in_valid input 1; uart_in_ch input 8; uart_out_valid output 1; uart_out_ch output 8; uart_out_ready input 1; uart_overflow output 1.

Function
REQ-014 SHALL implement FSM states HOLD, INIT, RUN, DUMP, DONE.
REQ-015 HOLD SHALL assert core_reset and count HOLD_CYCLES cycles, then enter INIT.
REQ-016 INIT SHALL deassert core_reset, pulse init_req exactly once on INIT entry, and enter RUN the cycle after init_ack is sampled high.
REQ-017 RUN SHALL increment cycles by 1 per cycle and add popcount(commit) to instrs per cycle; both saturate at all-ones, never wrap.
REQ-018 In RUN, the lowest-index core with trap_valid high SHALL be the stop cause: finish_code = its trap_code, finish_core = its index.
REQ-019 Otherwise, if cfg_max_instrs != 0 and next instrs >= cfg_max_instrs, stop with finish_code 8'h09, finish_core 8'hFF.
REQ-020 Otherwise, if cfg_max_cycles != 0 and next cycles >= cfg_max_cycles, stop with finish_code 8'hFE, finish_core 8'hFF.
REQ-021 Priority on simultaneous causes SHALL be trap > instruction limit > cycle limit; the cycle that stops still counts.
REQ-022 Stop SHALL enter DUMP next cycle; DUMP asserts perf_dump for exactly DUMP_CYCLES cycles, then enters DONE.
REQ-023 DONE SHALL assert finish continuously and ignore commit/trap inputs; counters and finish_code freeze.
REQ-024 Traps and commits outside RUN SHALL be ignored.
REQ-025 UART buffer SHALL be a UART_DEPTH-entry FIFO written when uart_in_valid is high in RUN or DUMP.
REQ-026 UART output SHALL be valid/ready: uart_out_valid = not empty; pop when uart_out_valid and uart_out_ready; draining continues in DONE.
REQ-027 Write when full SHALL drop the character and set sticky uart_overflow; simultaneous push and pop when full SHALL succeed with no overflow.
REQ-028 FIFO pointers SHALL wrap modulo UART_DEPTH with an extra bit distinguishing full from empty.

Reset
REQ-029 While reset is high: state = HOLD with hold counter cleared, core_reset = 1, init_req = 0, perf_dump = 0, finish = 0, finish_code = 0, finish_core = 0, cycles = 0, instrs = 0, FIFO empty, uart_overflow = 0.
REQ-030 Reset asserted in any state, including mid-DUMP, SHALL take effect on the next clock edge and restart the full sequence.

Verification
REQ-031 Reset 3 cycles, init_ack one cycle after init_req -> core_reset high for 50 cycles after reset falls, single init_req pulse, RUN entered.
REQ-032 NUM_CORES=2, commit=2'b11 for 10 RUN cycles, trap_valid=2'b10 with code 8'h01 -> instrs=20, finish_code=01, finish_core=1, perf_dump high 50 cycles, then finish=1.
REQ-033 trap_valid=2'b11 and instrs limit reached in same cycle -> core 0 code wins, finish_core=0.
REQ-034 cfg_max_cycles=100, cfg_max_instrs=0, no traps -> stop when cycles=100, finish_code=FE.
REQ-035 20 UART chars in RUN with uart_out_ready=0 -> 16 buffered, uart_overflow=1; release ready -> first 16 chars out in order.
REQ-036 Reset asserted mid-DUMP -> next cycle perf_dump=0, core_reset=1, counters 0, FIFO empty.
